timer_peripheral: RTL and testbench
===================================

Name: timer_peripheral

Overview:
Memory-mapped timer slave on the CPU data bus, decoded alongside data memory and the LED, BCD7, sysclk and UART windows. Holds the reload register TH, the counter TL and the control register TCON, plus a free-running read-only SYSTICK counter at the sysclk address. Raises an interrupt request on TL overflow. The bus read mux consumes its Read_data and hit outputs.

Parameters:
BASE_ADDR, 32'h40000000, byte address of TH; TL at +4, TCON at +8, SYSTICK at +20 (0x14).
PRESCALE, 1, number of clk cycles per TL increment; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
addr  input  32  byte address from the CPU memory stage.
Mem_rd  input  1  read strobe.
Mem_wr  input  1  write strobe, sampled on the clk rising edge.
Write_data  input  32  write data.
Read_data  output  32  combinational read data; 0 when not hit or Mem_rd=0.
hit  output  1  combinational; 1 when addr equals one of the four register addresses.
irq  output  1  registered timer interrupt request, TCON[1] & TCON[2].

Behaviour:
- Reset (reset=0, asynchronous): TH=0, TL=0, TCON=0, SYSTICK=0, prescale count=0, irq=0. Reset during counting takes effect immediately. No state is retained.
- Decode: exact word-address match only. Any other address in the window (e.g. BASE+0xC) gives hit=0, writes are ignored, and reads return 0.
- TCON: bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status (sticky). Bits [31:3] read as 0.
- Prescaler: counts 0..PRESCALE-1 while TCON[0]=1 and emits a tick when the count is PRESCALE-1. The count holds when TCON[0]=0 and clears to 0 on any TCON write.
- Tick with TL != 32'hFFFFFFFF: TL <= TL+1 on that edge.
- Tick with TL == 32'hFFFFFFFF: TL <= TH on that edge. If TCON[1]=1, TCON[2] <= 1 on the same edge, so irq rises the following cycle relative to the overflow edge.
- Write to TH: the new value takes effect at the edge. An overflow on the same edge reloads the old TH.
- Write to TL: CPU write wins over an increment or reload on the same edge. A simultaneous overflow still sets TCON[2].
- Write to TCON:
  - bits[1:0] <= Write_data[1:0].
  - bit2 clears only if Write_data[2]=0, otherwise it holds.
  - An overflow set on the same edge wins over the clear.
- SYSTICK: increments by 1 every clk regardless of TCON, wraps 0xFFFFFFFF -> 0. Writes are ignored, but hit is still 1.
- Reads: combinational; return current register values (pre-edge), independent of Mem_wr.
- Mem_rd=1 and Mem_wr=1 together: the read returns the old value and the write commits at the edge.

Decomposition:
- Shared package: address offset constants (OFF_TH, OFF_TL, OFF_TCON, OFF_SYSTICK) and TCON bit indices, so the bus decoder and this block share one definition.
- Natural sub-module: timer_prescaler (counter plus tick output, enable and sync clear inputs).
- Register file, decode and read mux stay in the top module.

Test Plan:
- Async reset: pulse reset=0 mid-count with TL=5 -> TL, TH, TCON, SYSTICK all read 0 immediately; irq=0.
- Count: PRESCALE=1, write TL=32'hFFFFFFFD, TH=32'h10, TCON=3 -> after 3 cycles TL=32'h10, TCON reads 7, irq=1 one cycle later.
- Interrupt clear: with TCON=7, write TCON=3 -> TCON reads 3 and irq=0 next cycle. Repeat the same write on an overflow edge -> TCON stays 7.
- Write priority: TL=32'hFFFFFFFF, enabled, write TL=32'h20 on the overflow edge -> TL=32'h20 and TCON[2]=1.
- Prescale: PRESCALE=4, TL=0, TCON=1 for 12 cycles -> TL=3. Clear TCON to 0 -> TL holds.
- Decode and SYSTICK:
  - Read BASE+0xC -> hit=0, Read_data=0.
  - Write 32'h1234 to SYSTICK -> ignored.
  - Two reads N cycles apart differ by exactly N.

Source files
------------

// File: rtl/timer_peripheral_pkg.sv
// Shared definitions for the timer peripheral: register offsets, TCON bit
// positions and the word-exact address decoder used by the bus read mux.
package timer_peripheral_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_SYSTICK
    } reg_sel_e;

    // Exact byte-address match only; holes inside the window decode to none.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] base);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == base + OFF_TH)           sel = SEL_TH;
        else if (addr == base + OFF_TL)      sel = SEL_TL;
        else if (addr == base + OFF_TCON)    sel = SEL_TCON;
        else if (addr == base + OFF_SYSTICK) sel = SEL_SYSTICK;
        return sel;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: one tick every PRESCALE enabled cycles, restarted by clr.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

    // Down-counter holding cycles remaining before the next tick; a fresh
    // period (TERM) is equivalent to an up-count starting at zero.
    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = TERM;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? TERM : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= TERM;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer: TH reload, TL counter, TCON control/status and a
// free-running SYSTICK, with a registered overflow interrupt request.
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq
);

    reg_sel_e    sel;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick, ovf;
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [31:0] systick_q, systick_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        irq_q, irq_d;

    assign sel     = decode_addr(addr, BASE_ADDR);
    assign hit     = (sel != SEL_NONE);
    assign wr_th   = Mem_wr && (sel == SEL_TH);
    assign wr_tl   = Mem_wr && (sel == SEL_TL);
    assign wr_tcon = Mem_wr && (sel == SEL_TCON);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (tcon_q[TCON_EN]),
        .clr  (wr_tcon),
        .tick (tick)
    );

    assign ovf = tick && (tl_q == 32'hFFFF_FFFF);

    // Overflow reloads from the pre-edge TH; a CPU write to TL overrides the
    // count, and an overflow status set beats a same-edge clear.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        irq_d     = tcon_q[TCON_IE] & tcon_q[TCON_IS];
        systick_d = systick_q + 32'd1;

        if (wr_th) th_d = Write_data;

        if (tick)  tl_d = ovf ? th_q : tl_q + 32'd1;
        if (wr_tl) tl_d = Write_data;

        if (wr_tcon) begin
            tcon_d[TCON_IE:TCON_EN] = Write_data[1:0];
            if (!Write_data[TCON_IS]) tcon_d[TCON_IS] = 1'b0;
        end
        if (ovf && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        Read_data = '0;
        if (Mem_rd) begin
            case (sel)
                SEL_TH:      Read_data = th_q;
                SEL_TL:      Read_data = tl_q;
                SEL_TCON:    Read_data = {29'd0, tcon_q};
                SEL_SYSTICK: Read_data = systick_q;
                default:     Read_data = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: two instances (PRESCALE 1 and 4) share the bus
// and are checked every cycle against a register-level model.
module tb_timer_peripheral;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'h4;
    localparam logic [31:0] A_TCON = BASE + 32'h8;
    localparam logic [31:0] A_HOLE = BASE + 32'hC;
    localparam logic [31:0] A_H10  = BASE + 32'h10;
    localparam logic [31:0] A_SYS  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;

    logic [31:0] rd_a, rd_b;
    logic        hit_a, hit_b, irq_a, irq_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .addr(addr), .Mem_rd(mem_rd), .Mem_wr(mem_wr),
        .Write_data(wdata), .Read_data(rd_a), .hit(hit_a), .irq(irq_a)
    );

    timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .addr(addr), .Mem_rd(mem_rd), .Mem_wr(mem_wr),
        .Write_data(wdata), .Read_data(rd_b), .hit(hit_b), .irq(irq_b)
    );

    // Model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4.
    logic [31:0] m_th[2]   = '{default: '0};
    logic [31:0] m_tl[2]   = '{default: '0};
    logic [31:0] m_sys[2]  = '{default: '0};
    logic [2:0]  m_tcon[2] = '{default: '0};
    logic        m_irq[2]  = '{default: 1'b0};
    int          m_phase[2] = '{default: 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_th[k] <= '0; m_tl[k] <= '0; m_sys[k] <= '0;
                m_tcon[k] <= '0; m_irq[k] <= 1'b0; m_phase[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic int   p     = (k == 0) ? 1 : 4;
                automatic logic wth   = mem_wr && addr == A_TH;
                automatic logic wtl   = mem_wr && addr == A_TL;
                automatic logic wtc   = mem_wr && addr == A_TCON;
                automatic logic tk    = m_tcon[k][0] && (m_phase[k] == p - 1);
                automatic logic ov    = tk && (m_tl[k] == 32'hFFFF_FFFF);
                automatic logic stat  = m_tcon[k][2];
                if (wtc && !wdata[2]) stat = 1'b0;
                if (ov && m_tcon[k][1]) stat = 1'b1;
                m_th[k]   <= wth ? wdata : m_th[k];
                m_tl[k]   <= wtl ? wdata : (ov ? m_th[k] : (tk ? m_tl[k] + 1 : m_tl[k]));
                m_tcon[k] <= {stat, wtc ? wdata[1:0] : m_tcon[k][1:0]};
                m_phase[k] <= wtc ? 0 : (m_tcon[k][0] ? (m_phase[k] + 1) % p : m_phase[k]);
                m_irq[k]  <= m_tcon[k][1] & m_tcon[k][2];
                m_sys[k]  <= m_sys[k] + 1;
            end
        end
    end

    function automatic logic m_hit(input logic [31:0] a);
        return (a == A_TH) || (a == A_TL) || (a == A_TCON) || (a == A_SYS);
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [31:0] a, input logic r);
        if (!r) return '0;
        if (a == A_TH)   return m_th[k];
        if (a == A_TL)   return m_tl[k];
        if (a == A_TCON) return {29'd0, m_tcon[k]};
        if (a == A_SYS)  return m_sys[k];
        return '0;
    endfunction

    // Literal expectations posted by the stimulus, checked at the next negedge.
    logic        lit_on = 1'b0;
    int          lit_dut = 0;
    string       lit_name = "";
    logic [31:0] lit_rd = '0;
    logic        lit_hit = 1'b0;
    logic        lit_irq_on = 1'b0;
    logic        lit_irq = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_rd_p1",  rd_a,  m_read(0, addr, mem_rd));
        cmp("model_hit_p1", {31'd0, hit_a}, {31'd0, m_hit(addr)});
        cmp("model_irq_p1", {31'd0, irq_a}, {31'd0, m_irq[0]});
        cmp("model_rd_p4",  rd_b,  m_read(1, addr, mem_rd));
        cmp("model_hit_p4", {31'd0, hit_b}, {31'd0, m_hit(addr)});
        cmp("model_irq_p4", {31'd0, irq_b}, {31'd0, m_irq[1]});
        if (lit_on) begin
            cmp({lit_name, "_rd"},  (lit_dut == 0) ? rd_a : rd_b, lit_rd);
            cmp({lit_name, "_hit"}, {31'd0, (lit_dut == 0) ? hit_a : hit_b}, {31'd0, lit_hit});
            if (lit_irq_on)
                cmp({lit_name, "_irq"}, {31'd0, (lit_dut == 0) ? irq_a : irq_b}, {31'd0, lit_irq});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_wr = 1'b1; mem_rd = 1'b0;
        step(1);
        mem_wr = 1'b0;
    endtask

    task automatic lit(input string nm, input int dut, input logic [31:0] a,
                       input logic [31:0] exp_rd, input logic exp_hit,
                       input logic irq_on, input logic exp_irq);
        addr = a; mem_rd = 1'b1;
        lit_name = nm; lit_dut = dut; lit_rd = exp_rd; lit_hit = exp_hit;
        lit_irq_on = irq_on; lit_irq = exp_irq; lit_on = 1'b1;
        step(1);
        lit_on = 1'b0; mem_rd = 1'b0;
    endtask

    logic [31:0] s0;

    initial begin
        step(3);
        reset = 1'b1;
        lit("sys_after_reset", 0, A_SYS, 32'd0, 1'b1, 1'b1, 1'b0);
        lit("sys_one",         0, A_SYS, 32'd1, 1'b1, 1'b0, 1'b0);
        lit("rst_tcon",        0, A_TCON, 32'd0, 1'b1, 1'b1, 1'b0);
        lit("rst_th",          1, A_TH,   32'd0, 1'b1, 1'b0, 1'b0);

        do_write(A_TL, 32'hFFFF_FFFD);
        do_write(A_TH, 32'h0000_0010);
        do_write(A_TCON, 32'd3);
        lit("cnt_fd",   0, A_TL,   32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        lit("cnt_fe",   0, A_TL,   32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        lit("cnt_ff",   0, A_TL,   32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        lit("reload",   0, A_TL,   32'h0000_0010, 1'b1, 1'b1, 1'b0);
        lit("ovf_tcon", 0, A_TCON, 32'd7,         1'b1, 1'b1, 1'b1);

        do_write(A_TCON, 32'd3);
        lit("clr_tcon",      0, A_TCON, 32'd3, 1'b1, 1'b1, 1'b1);
        lit("clr_irq_drops", 0, A_TCON, 32'd3, 1'b1, 1'b1, 1'b0);

        do_write(A_TL, 32'hFFFF_FFFE);
        step(1);
        do_write(A_TCON, 32'd3);
        lit("ovf_beats_clr", 0, A_TCON, 32'd7, 1'b1, 1'b1, 1'b0);

        do_write(A_TCON, 32'd3);
        do_write(A_TL, 32'hFFFF_FFFF);
        do_write(A_TH, 32'h0000_0055);
        lit("reload_old_th", 0, A_TL, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
        lit("th_new",        0, A_TH, 32'h0000_0055, 1'b1, 1'b0, 1'b0);

        do_write(A_TCON, 32'd3);
        do_write(A_TL, 32'hFFFF_FFFF);
        do_write(A_TL, 32'h0000_0020);
        lit("tl_wr_wins",   0, A_TL,   32'h0000_0020, 1'b1, 1'b0, 1'b0);
        lit("tl_wr_status", 0, A_TCON, 32'd7,         1'b1, 1'b0, 1'b0);

        mem_wr = 1'b1; wdata = 32'h0000_0077;
        lit("rw_old_th", 0, A_TH, 32'h0000_0055, 1'b1, 1'b0, 1'b0);
        mem_wr = 1'b0;
        lit("rw_new_th", 0, A_TH, 32'h0000_0077, 1'b1, 1'b0, 1'b0);

        lit("hole_c",  0, A_HOLE, 32'd0, 1'b0, 1'b0, 1'b0);
        do_write(A_HOLE, 32'hFFFF_FFFF);
        lit("hole_10", 1, A_H10, 32'd0, 1'b0, 1'b0, 1'b0);
        lit("th_keep", 0, A_TH, 32'h0000_0077, 1'b1, 1'b0, 1'b0);

        addr = A_SYS; mem_rd = 1'b1;
        #1 s0 = rd_a;
        mem_rd = 1'b0;
        do_write(A_SYS, 32'h0000_1234);
        step(4);
        lit("sys_delta", 0, A_SYS, s0 + 32'd5, 1'b1, 1'b0, 1'b0);

        do_write(A_TCON, 32'd1);
        do_write(A_TL, 32'd5);
        reset = 1'b0;
        lit("arst_tl",   0, A_TL,   32'd0, 1'b1, 1'b1, 1'b0);
        lit("arst_th",   0, A_TH,   32'd0, 1'b1, 1'b0, 1'b0);
        lit("arst_tcon", 1, A_TCON, 32'd0, 1'b1, 1'b1, 1'b0);
        lit("arst_sys",  0, A_SYS,  32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;

        do_write(A_TL, 32'd0);
        do_write(A_TCON, 32'd1);
        step(12);
        lit("pre4_tl3", 1, A_TL, 32'd3, 1'b1, 1'b0, 1'b0);
        do_write(A_TCON, 32'd0);
        step(8);
        lit("pre4_hold", 1, A_TL, 32'd3, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
